tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Parametrised, synthesisable successor to the fixed 3-in/3-out truth-table testbench stimulator/tester.
- Sweeps every input vector 0..2^IN_W-1 into a combinational DUT and waits a programmable settle time. It then samples the DUT outputs and compares them against a per-channel truth-table parameter.
- Reports error count, first failing vector and pass/fail. Used as on-chip BIST around small logic blocks and as a reusable bench component.

Parameters:
- IN_W, 3: DUT input width; the sweep covers 2^IN_W vectors.
- OUT_N, 3: number of DUT output channels checked.
- TT, {8'b01010101, 8'b00111001, 8'b00100011}: OUT_N*2^IN_W bits. The table for channel k is TT[k*2^IN_W +: 2^IN_W], and bit v of that slice is the expected output for vector v.
- SETTLE, 6: clock cycles between driving a vector and sampling it. Must be >=1.
- CNT_W, 8: error-counter width.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- stim, out, IN_W: vector driven to the DUT.
- resp, in, OUT_N: DUT outputs; resp[k] is channel k.
- check_pulse, out, 1: high for the one cycle in which resp is compared.
- busy, out, 1: sweep in progress.
- done, out, 1: sweep finished. Held until the next start or reset.
- pass, out, 1: valid when done=1. 1 means no mismatches.
- err_cnt, out, CNT_W: number of mismatching vectors. Saturates at all-ones.
- first_err_vec, out, IN_W: first mismatching vector.
- first_err_mask, out, OUT_N: channels that mismatched at first_err_vec.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. stim, check_pulse, busy, done, pass, err_cnt, first_err_vec and first_err_mask are all 0.
- A reset during a sweep aborts it immediately. No partial result is retained.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1: next cycle state=SETTLE, vec=0, stim=0, settle counter=0, busy=1, done=0, pass=0, err_cnt=0, first_err fields=0, internal first-error flag cleared.
- SETTLE: the counter increments each cycle. After SETTLE cycles in this state, go to CHECK.
- CHECK: lasts one cycle, with check_pulse=1.
  - exp[k] = TT[k*2^IN_W + vec]; mismatch = resp ^ exp.
  - If mismatch is non-zero, err_cnt increments (saturating). If no error has been recorded yet, first_err_vec<=vec, first_err_mask<=mismatch, and the flag is set.
  - If vec is the last vector (all-ones), next state is DONE. Otherwise vec and stim increment, the counter clears, and the FSM returns to SETTLE.
- Timing: stim is stable for SETTLE+1 cycles per vector. A full sweep is 2^IN_W*(SETTLE+1) busy cycles; the default is 56.
- DONE: busy=0, done=1. pass=1 iff err_cnt==0, registered on entry. stim holds the last vector.
- start while busy (SETTLE/CHECK) is ignored.
- start in DONE restarts the sweep, with the same timing as from IDLE.
- stim wraps only through restart; vec never increments past the all-ones vector.
- resp is sampled only in CHECK; its value at all other times is don't-care.

Optional Feature:
- Macro: TT_STOP_ON_ERR_EN.
- Defined: the first mismatching CHECK goes straight to DONE after recording. err_cnt is then 1, pass=0, and stim holds the failing vector.
- Undefined: the full sweep always completes, and err_cnt counts every mismatching vector.

Test Plan:
- Golden DUT model (resp = exp; vector 0 gives 3'b111, vector 3 gives 3'b010), start pulse -> busy for 56 cycles, check_pulse 8 times, done=1, pass=1, err_cnt=0.
- resp[1] stuck at 0 -> mismatches at vectors 0, 3, 4, 5. Result: err_cnt=4, first_err_vec=0, first_err_mask=3'b010, pass=0.
- CNT_W=2, resp=~exp -> all 8 vectors mismatch. Result: err_cnt saturates at 3, first_err_mask=3'b111, pass=0.
- rst_n low while stim=4 in SETTLE -> all outputs 0 asynchronously, state IDLE. A new start runs a clean 56-cycle sweep.
- start re-asserted during the sweep -> ignored, done still at cycle 56. start in DONE -> restarts with err_cnt cleared.
- With TT_STOP_ON_ERR_EN defined and resp[2] stuck at 1 (first mismatch at vector 1) -> done after 14 cycles, err_cnt=1, first_err_vec=1, stim=1.

Source files
------------

// File: rtl/tt_sweep_checker.sv
//==============================================================================
// Module : tt_sweep_checker
// Sweeps all 2^IN_W input vectors into a combinational block and checks each
// output channel against a truth-table parameter.
// Optional : TT_STOP_ON_ERR_EN - end the sweep at the first mismatching vector.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tt_sweep_checker #(
    parameter int IN_W   = 3,
    parameter int OUT_N  = 3,
    parameter logic [OUT_N*(2**IN_W)-1:0] TT = {8'b01010101, 8'b00111001, 8'b00100011},
    parameter int SETTLE = 6,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_N-1:0] resp,
    output logic             check_pulse,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IN_W-1:0]  first_err_vec,
    output logic [OUT_N-1:0] first_err_mask
);

    localparam int N_VEC = 2**IN_W;
    localparam int SC_W  = $clog2(SETTLE + 1);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SC_W-1:0]  settle_cnt;
    logic             first_seen;
    logic [OUT_N-1:0] exp_vec;
    logic [OUT_N-1:0] mismatch;
    logic             has_err;
    logic             stop_now;

    // Expected value of each channel for the vector currently on stim.
    for (genvar k = 0; k < OUT_N; k++) begin : g_exp
        localparam logic [N_VEC-1:0] CH_TT = TT[k*N_VEC +: N_VEC];
        assign exp_vec[k] = CH_TT[stim];
    end

    assign mismatch = resp ^ exp_vec;
    assign has_err  = |mismatch;

`ifdef TT_STOP_ON_ERR_EN
    assign stop_now = (stim == {IN_W{1'b1}}) || has_err;
`else
    assign stop_now = (stim == {IN_W{1'b1}});
`endif

    always_comb begin
        state_nx    = state;
        check_pulse = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nx = S_CHECK;
            end
            S_CHECK: begin
                busy        = 1'b1;
                check_pulse = 1'b1;
                state_nx    = stop_now ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_SETTLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            stim           <= '0;
            settle_cnt     <= '0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_vec  <= '0;
            first_err_mask <= '0;
            first_seen     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        stim           <= '0;
                        settle_cnt     <= '0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_vec  <= '0;
                        first_err_mask <= '0;
                        first_seen     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_CHECK: begin
                    if (has_err) begin
                        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
                        if (!first_seen) begin
                            first_err_vec  <= stim;
                            first_err_mask <= mismatch;
                            first_seen     <= 1'b1;
                        end
                    end
                    // Count never wraps to zero, so an error flag is enough for pass.
                    if (stop_now) begin
                        pass <= !(first_seen || has_err);
                    end else begin
                        stim       <= stim + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
//==============================================================================
// Module : tb_tt_sweep_checker
// Randomised scoreboard bench for tt_sweep_checker (CNT_W=8 and CNT_W=2 copies).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_tt_sweep_checker;

    localparam int SETTLE = 6;
    localparam int NV     = 8;
`ifdef TT_STOP_ON_ERR_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] stim, stim_s, resp, resp_s;
    logic       check_pulse, busy, done, pass;
    logic       check_pulse_s, busy_s, done_s, pass_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;
    logic [2:0] first_err_vec, first_err_mask, first_err_vec_s, first_err_mask_s;
    logic [2:0] fault [NV];

    always #5 clk = ~clk;

    // Truth table written channel by channel, as a designer would list it.
    function automatic logic [2:0] golden(input int v);
        logic [7:0] c0, c1, c2;
        c0 = 8'b00100011;
        c1 = 8'b00111001;
        c2 = 8'b01010101;
        return {c2[v], c1[v], c0[v]};
    endfunction

    assign resp   = golden(int'(stim))   ^ fault[stim];
    assign resp_s = golden(int'(stim_s)) ^ fault[stim_s];

    tt_sweep_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
        .check_pulse(check_pulse), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_vec(first_err_vec), .first_err_mask(first_err_mask)
    );

    tt_sweep_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_s), .resp(resp_s),
        .check_pulse(check_pulse_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_cnt(err_cnt_s), .first_err_vec(first_err_vec_s), .first_err_mask(first_err_mask_s)
    );

    typedef struct {
        int         err;
        int         err_sat;
        int         fvec;
        logic [2:0] fmask;
        logic       pass;
        int         busy_cyc;
        int         last_vec;
    } res_t;

    res_t res_q[$];
    int   chk_q[$];
    res_t mr;
    int   passed = 0;
    int   total  = 0;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: walk the fault table vector by vector.
    task automatic push_expect();
        res_t r;
        int   n;
        n = 0;
        r.err = 0; r.fvec = 0; r.fmask = 3'b000;
        for (int v = 0; v < NV; v++) begin
            chk_q.push_back(v);
            n++;
            if (fault[v] != 3'b000) begin
                if (r.err == 0) begin
                    r.fvec  = v;
                    r.fmask = fault[v];
                end
                r.err++;
                if (STOP_EN) break;
            end
        end
        r.err_sat  = (r.err > 3) ? 3 : r.err;
        r.pass     = (r.err == 0);
        r.busy_cyc = n * (SETTLE + 1);
        r.last_vec = n - 1;
        res_q.push_back(r);
    endtask

    task automatic set_fault(input int mode);
        for (int v = 0; v < NV; v++) begin
            case (mode)
                0: fault[v] = 3'b000;
                1: fault[v] = golden(v) & 3'b010;
                2: fault[v] = 3'b111;
                3: fault[v] = ~golden(v) & 3'b100;
                default: fault[v] = ($urandom_range(0, 2) == 0) ? 3'(($urandom % 7) + 1) : 3'b000;
            endcase
        end
    endtask

    // Monitor: pops the scoreboard on every check_pulse and on done's rising edge.
    logic done_q = 1'b0;
    logic busy_q = 1'b0;
    int   busy_n = 0;

    always @(negedge clk) begin
        done_q <= done & rst_n;
        busy_q <= busy & rst_n;
        if (!rst_n)              busy_n <= 0;
        else if (busy && !busy_q) busy_n <= 1;
        else if (busy)            busy_n <= busy_n + 1;

        if (rst_n && check_pulse) begin
            if (chk_q.size() == 0) cmp("spurious_check_pulse", 1, 0);
            else                   cmp("check_vec", int'(stim), chk_q.pop_front());
            cmp("sat_in_step", int'(check_pulse_s), 1);
        end
        if (rst_n && done && !done_q) begin
            if (res_q.size() == 0) begin
                cmp("spurious_done", 1, 0);
            end else begin
                mr = res_q.pop_front();
                cmp("err_cnt",        int'(err_cnt),        mr.err);
                cmp("first_err_vec",  int'(first_err_vec),  mr.fvec);
                cmp("first_err_mask", int'(first_err_mask), int'(mr.fmask));
                cmp("pass",           int'(pass),           int'(mr.pass));
                cmp("busy_cycles",    busy_n,               mr.busy_cyc);
                cmp("stim_hold",      int'(stim),           mr.last_vec);
                cmp("err_cnt_sat",    int'(err_cnt_s),      mr.err_sat);
                cmp("pass_sat",       int'(pass_s),         int'(mr.pass));
                cmp("checks_left",    chk_q.size(),         0);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic launch();
        push_expect();
        pulse_start();
        cmp("start_busy",  int'(busy),    1);
        cmp("start_done",  int'(done),    0);
        cmp("start_clear", int'({err_cnt, first_err_vec, first_err_mask, pass, stim}), 0);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 200) begin
            cmp("done_timeout", 0, 1);
            chk_q.delete();
            res_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        cmp(name, int'({stim, check_pulse, busy, done, pass, err_cnt,
                        first_err_vec, first_err_mask}), 0);
        cmp({name, "_sat"}, int'({stim_s, busy_s, done_s, pass_s, err_cnt_s}), 0);
    endtask

    initial begin
        set_fault(0);
        #1 check_reset_state("reset_state");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int m = 0; m < 4; m++) begin
            set_fault(m);
            launch();
            wait_done();
        end

        // Reset in the middle of the sweep, while vector 4 is settling.
        set_fault(0);
        launch();
        for (int k = 0; k < 100 && stim != 3'd4; k++) @(negedge clk);
        cmp("reach_vec4", int'(stim), 4);
        @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        chk_q.delete();
        res_q.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        launch();
        wait_done();

        // start re-asserted mid-sweep must be ignored.
        set_fault(1);
        launch();
        repeat (20) @(negedge clk);
        pulse_start();
        wait_done();

        // Back-to-back random sweeps restart straight from DONE.
        for (int i = 0; i < 6; i++) begin
            set_fault(4);
            launch();
            wait_done();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
